// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous imem and registers the IF/ID latch.
// Optional build macro FETCH_PERF_EN adds saturating fetched/bubble performance counters.
module fetch_stage #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP      = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              ifid_valid,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    logic              primed;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_next;

    // Natural ADDR_W-bit wrap from the all-ones address back to zero.
    assign pc_plus1 = pc + ADDR_W'(1);

    always_comb begin
        // NOTE: assign a default before the priority chain so no path leaves pc_next unassigned (no latch).
        pc_next = pc_plus1;
        if (!primed) begin
            pc_next = pc;
        end else if (redirect) begin
            pc_next = redirect_target;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    assign imem_addr = pc_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= RESET_PC;
            primed        <= 1'b0;
            ifid_instr    <= NOP;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            pc <= pc_next;
            if (!primed) begin
                // imem_q is stale until the ROM has seen pc once; inject a bubble.
                primed     <= 1'b1;
                ifid_instr <= NOP;
                ifid_valid <= 1'b0;
            end else if (redirect) begin
                ifid_instr    <= NOP;
                ifid_valid    <= 1'b0;
                ifid_pc       <= pc;
                ifid_pc_plus1 <= pc_plus1;
            end else if (!stall) begin
                ifid_instr    <= imem_q;
                ifid_valid    <= 1'b1;
                ifid_pc       <= pc;
                ifid_pc_plus1 <= pc_plus1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else if (primed) begin
            if (redirect || stall) begin
                if (perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
            end else begin
                if (perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic
// compared against a behavioural fetch model driven by a synchronous ROM model.
module tb_fetch_stage;

    localparam int        AW    = 12;
    localparam int        DEPTH = 1 << AW;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic [31:0]   ifid_instr;
    logic [AW-1:0] ifid_pc;
    logic [AW-1:0] ifid_pc_plus1;
    logic          ifid_valid;
    logic [AW-1:0] pc;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_bubbles;
`endif

    fetch_stage #(.ADDR_W(AW), .RESET_PC('0), .NOP(NOP)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus1   (ifid_pc_plus1),
        .ifid_valid      (ifid_valid),
        .pc              (pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction ROM.
    logic [31:0] mem [DEPTH];
    always @(posedge clock) imem_q <= mem[imem_addr];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: fetch state expressed as plain integers.
    int     m_pc, m_ifpc, m_ifpc1;
    bit     m_primed, m_valid;
    logic [31:0] m_instr;
    longint m_fetched, m_bubbles;

    function automatic int wrap(input int a);
        return a % DEPTH;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ifpc = 0; m_ifpc1 = 0; m_primed = 0; m_valid = 0;
        m_instr = NOP; m_fetched = 0; m_bubbles = 0;
    endtask

    function automatic int exp_addr();
        if (!m_primed) return m_pc;
        if (redirect)  return int'(redirect_target);
        if (stall)     return m_pc;
        return wrap(m_pc + 1);
    endfunction

    task automatic model_edge();
        if (!m_primed) begin
            m_primed = 1; m_instr = NOP; m_valid = 0;
        end else if (redirect) begin
            m_ifpc = m_pc; m_ifpc1 = wrap(m_pc + 1);
            m_instr = NOP; m_valid = 0;
            m_pc = int'(redirect_target);
            if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
        end else if (stall) begin
            if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
        end else begin
            m_instr = mem[m_pc]; m_valid = 1;
            m_ifpc = m_pc; m_ifpc1 = wrap(m_pc + 1);
            m_pc = wrap(m_pc + 1);
            if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
        check({tag, ".instr"}, ifid_instr, m_instr);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check({tag, ".ifid_pc"}, 32'(ifid_pc), 32'(m_ifpc));
        if (m_valid) check({tag, ".pc_plus1"}, 32'(ifid_pc_plus1), 32'(m_ifpc1));
`ifdef FETCH_PERF_EN
        check({tag, ".perf_fetched"}, perf_fetched, 32'(m_fetched));
        check({tag, ".perf_bubbles"}, perf_bubbles, 32'(m_bubbles));
`endif
    endtask

    // One clock cycle: apply inputs, check the combinational address, then the registered outputs.
    task automatic step(input string tag, input logic s, input logic r, input int t);
        stall = s; redirect = r; redirect_target = AW'(t);
        #1;
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(exp_addr()));
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++)
            mem[k] = (k < 64) ? 32'(k + 100) : $urandom;

        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        model_reset();
        #3;
        check("reset.imem_addr", 32'(imem_addr), 32'd0);
        check_outputs("reset");
        #4 reset_n = 1'b1;

        // Prime cycle, then sequential fetch from 0.
        step("prime", 0, 0, 0);
        check("prime.valid_lit", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step("seq", 0, 0, 0);
            check("seq.instr_lit", ifid_instr, 32'(100 + i));
            check("seq.ifid_pc_lit", 32'(ifid_pc), 32'(i));
            check("seq.plus1_lit", 32'(ifid_pc_plus1), 32'(i + 1));
        end

        // Stall for 3 cycles while ifid_pc = 5.
        for (int i = 0; i < 3; i++) step("to5", 0, 0, 0);
        check("to5.ifid_pc_lit", 32'(ifid_pc), 32'd5);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 0);
            check("stall.ifid_pc_lit", 32'(ifid_pc), 32'd5);
            check("stall.instr_lit", ifid_instr, 32'd105);
            check("stall.pc_lit", 32'(pc), 32'd6);
        end
        step("unstall", 0, 0, 0);
        check("unstall.ifid_pc_lit", 32'(ifid_pc), 32'd6);

        // Redirect to 40 while pc = 9.
        while (m_pc != 9) step("to9", 0, 0, 0);
        step("redir", 0, 1, 40);
        check("redir.valid_lit", 32'(ifid_valid), 32'd0);
        check("redir.instr_lit", ifid_instr, NOP);
        check("redir.pc_lit", 32'(pc), 32'd40);
        step("after_redir", 0, 0, 0);
        check("after_redir.ifid_pc_lit", 32'(ifid_pc), 32'd40);
        check("after_redir.instr_lit", ifid_instr, 32'd140);

        // Redirect and stall together: redirect wins.
        step("redir_stall", 1, 1, 20);
        check("redir_stall.pc_lit", 32'(pc), 32'd20);
        check("redir_stall.valid_lit", 32'(ifid_valid), 32'd0);

        // PC wrap at the top of the address space.
        step("wrap_redir", 0, 1, DEPTH - 2);
        step("wrap0", 0, 0, 0);
        check("wrap0.ifid_pc_lit", 32'(ifid_pc), 32'(DEPTH - 2));
        step("wrap1", 0, 0, 0);
        check("wrap1.ifid_pc_lit", 32'(ifid_pc), 32'(DEPTH - 1));
        check("wrap1.plus1_lit", 32'(ifid_pc_plus1), 32'd0);
        step("wrap2", 0, 0, 0);
        check("wrap2.ifid_pc_lit", 32'(ifid_pc), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(99) < 20), ($urandom_range(99) < 10), int'($urandom_range(DEPTH - 1)));

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset.imem_addr", 32'(imem_addr), 32'd0);
        check_outputs("midreset");
        @(posedge clock);
        #1;
        check_outputs("midreset_hold");
        #2 reset_n = 1'b1;
        step("reprime", 0, 0, 0);
        check("reprime.valid_lit", 32'(ifid_valid), 32'd0);
        step("refetch", 0, 0, 0);
        check("refetch.instr_lit", ifid_instr, 32'd100);

        for (int i = 0; i < 200; i++)
            step("rand2", ($urandom_range(99) < 25), ($urandom_range(99) < 10), int'($urandom_range(DEPTH - 1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
